// File: rtl/piezo_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piezo_arb_if
// Brief    : Request/tone bundle between the piezo arbiter and its clients.
// Revision : 1.0 - initial release
// ============================================================================
interface piezo_arb_if;
  logic       obst_req;
  logic       err_req;
  logic       arrive_req;
  logic       pwm_sig;
  logic [9:0] duty;
  logic       buzz;
  logic       buzz_n;
  logic       busy;
  logic [1:0] src;

  modport master (
    output obst_req, err_req, arrive_req, pwm_sig,
    input  duty, buzz, buzz_n, busy, src
  );

  modport slave (
    input  obst_req, err_req, arrive_req, pwm_sig,
    output duty, buzz, buzz_n, busy, src
  );
endinterface
`default_nettype wire

// File: rtl/piezo_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piezo_arb
// Brief    : Arbitrates obstacle/error/arrival alarms onto one piezo and pwm.
//            Macro PIEZO_CHIME_EN enables the arrival chime.
// Revision : 1.0 - initial release
// ============================================================================
module piezo_arb #(
  parameter logic [23:0] BEEP_CYC = 24'd12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  piezo_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OBST     = 2'd1,
    BEEP_ON  = 2'd2,
    BEEP_OFF = 2'd3
  } state_t;

  localparam logic [1:0]  c_SRC_NONE = 2'b00;
  localparam logic [1:0]  c_SRC_OBST = 2'b01;
  localparam logic [1:0]  c_SRC_ERR  = 2'b10;
  localparam logic [1:0]  c_SRC_ARR  = 2'b11;
  localparam logic [9:0]  c_DUTY_ERR = 10'h1FF;
  localparam logic [9:0]  c_DUTY_ARR = 10'h0FF;
  localparam logic [23:0] c_CYC_M1   = BEEP_CYC - 24'd1;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_timer, w_timer_nxt;
  logic [1:0]  r_beeps, w_beeps_nxt;
  logic        r_ext, w_ext_nxt;
  logic        r_pend_err, w_pend_err_nxt;
  logic        r_pend_arr, w_pend_arr_nxt;
  logic        r_tone_on, w_tone_nxt;
  logic [9:0]  r_duty, w_duty_nxt;
  logic [1:0]  r_src, w_src_nxt;
  logic        w_arr_req;
  logic        w_timer_done;

`ifdef PIEZO_CHIME_EN
  assign w_arr_req = bus.arrive_req;
`else
  logic w_unused_arrive;
  assign w_unused_arrive = bus.arrive_req;
  assign w_arr_req       = 1'b0;
`endif

  assign w_timer_done = (r_timer == 24'd0);

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_beeps_nxt    = r_beeps;
    w_ext_nxt      = r_ext;
    w_duty_nxt     = r_duty;
    w_src_nxt      = r_src;
    w_pend_err_nxt = r_pend_err | bus.err_req;
    w_pend_arr_nxt = r_pend_arr | w_arr_req;

    case (r_state)
      IDLE: begin
        if (bus.obst_req) begin
          w_state_nxt = OBST;
          w_timer_nxt = 24'd0;
          w_beeps_nxt = 2'd0;
          w_ext_nxt   = 1'b0;
          w_duty_nxt  = c_DUTY_ERR;
          w_src_nxt   = c_SRC_OBST;
        end else if (r_pend_err) begin
          w_state_nxt    = BEEP_ON;
          w_timer_nxt    = c_CYC_M1;
          w_beeps_nxt    = 2'd3;
          w_ext_nxt      = 1'b0;
          w_duty_nxt     = c_DUTY_ERR;
          w_src_nxt      = c_SRC_ERR;
          w_pend_err_nxt = bus.err_req;
        end else if (r_pend_arr) begin
          // Arrival tone is two timer periods long; r_ext marks the first.
          w_state_nxt    = BEEP_ON;
          w_timer_nxt    = c_CYC_M1;
          w_beeps_nxt    = 2'd1;
          w_ext_nxt      = 1'b1;
          w_duty_nxt     = c_DUTY_ARR;
          w_src_nxt      = c_SRC_ARR;
          w_pend_arr_nxt = w_arr_req;
        end
      end

      OBST: begin
        if (!bus.obst_req) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 24'd0;
          w_beeps_nxt = 2'd0;
          w_ext_nxt   = 1'b0;
          w_src_nxt   = c_SRC_NONE;
        end
      end

      BEEP_ON, BEEP_OFF: begin
        if (bus.obst_req) begin
          // Re-arm the interrupted pattern so it replays from its first beep.
          w_state_nxt = OBST;
          w_timer_nxt = 24'd0;
          w_beeps_nxt = 2'd0;
          w_ext_nxt   = 1'b0;
          w_duty_nxt  = c_DUTY_ERR;
          w_src_nxt   = c_SRC_OBST;
          if (r_src == c_SRC_ARR) w_pend_arr_nxt = 1'b1;
          else                    w_pend_err_nxt = 1'b1;
        end else if (!w_timer_done) begin
          w_timer_nxt = r_timer - 24'd1;
        end else if (r_state == BEEP_ON) begin
          w_timer_nxt = c_CYC_M1;
          if (r_ext) w_ext_nxt   = 1'b0;
          else       w_state_nxt = BEEP_OFF;
        end else if (r_beeps <= 2'd1) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 24'd0;
          w_beeps_nxt = 2'd0;
          w_src_nxt   = c_SRC_NONE;
        end else begin
          w_state_nxt = BEEP_ON;
          w_timer_nxt = c_CYC_M1;
          w_beeps_nxt = r_beeps - 2'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_src_nxt   = c_SRC_NONE;
      end
    endcase

`ifndef PIEZO_CHIME_EN
    w_pend_arr_nxt = 1'b0;
`endif

    w_tone_nxt = (w_state_nxt == OBST) || (w_state_nxt == BEEP_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_timer    <= 24'd0;
      r_beeps    <= 2'd0;
      r_ext      <= 1'b0;
      r_pend_err <= 1'b0;
      r_pend_arr <= 1'b0;
      r_tone_on  <= 1'b0;
      r_duty     <= 10'h000;
      r_src      <= c_SRC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_beeps    <= w_beeps_nxt;
      r_ext      <= w_ext_nxt;
      r_pend_err <= w_pend_err_nxt;
      r_pend_arr <= w_pend_arr_nxt;
      r_tone_on  <= w_tone_nxt;
      r_duty     <= w_duty_nxt;
      r_src      <= w_src_nxt;
    end
  end

  assign bus.duty   = r_duty;
  assign bus.src    = r_src;
  assign bus.busy   = (r_state != IDLE);
  assign bus.buzz   =  bus.pwm_sig & r_tone_on;
  assign bus.buzz_n = ~bus.pwm_sig & r_tone_on;

endmodule
`default_nettype wire

// File: tb/tb_piezo_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_piezo_arb
// Brief    : Directed self-checking bench for piezo_arb with BEEP_CYC = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_arb;

  localparam logic [23:0] c_CYC = 24'd8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  piezo_arb_if bus();

  piezo_arb #(.BEEP_CYC(c_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then pick a fresh pwm level before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.pwm_sig = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic expect_out(input string tag, input logic eb, input logic [1:0] es,
                            input logic et, input logic [9:0] ed);
    logic p;
    p = bus.pwm_sig;
    check({tag, ".busy"},   32'(bus.busy),   32'(eb));
    check({tag, ".src"},    32'(bus.src),    32'(es));
    check({tag, ".duty"},   32'(bus.duty),   32'(ed));
    check({tag, ".buzz"},   32'(bus.buzz),   32'(p & et));
    check({tag, ".buzz_n"}, 32'(bus.buzz_n), 32'(~p & et));
  endtask

  // Error pattern timeline: rel 1 is the first cycle after the start edge.
  function automatic logic err_busy(input int rel);
    return (rel >= 1) && (rel <= 48);
  endfunction

  function automatic logic err_on(input int rel);
    return err_busy(rel) && (((rel - 1) % 16) < 8);
  endfunction

  task automatic err_cycles(input string tag, input int first_rel, input int last_rel);
    for (int rel = first_rel; rel <= last_rel; rel++) begin
      tick();
      expect_out($sformatf("%s[%0d]", tag, rel), err_busy(rel),
                 err_busy(rel) ? 2'b10 : 2'b00, err_on(rel), 10'h1FF);
    end
  endtask

  task automatic pulse_err();
    bus.err_req = 1'b1;
    tick();
    bus.err_req = 1'b0;
  endtask

`ifdef PIEZO_CHIME_EN
  task automatic arr_cycles(input string tag);
    for (int rel = 1; rel <= 26; rel++) begin
      tick();
      expect_out($sformatf("%s[%0d]", tag, rel), rel <= 24,
                 (rel <= 24) ? 2'b11 : 2'b00, rel <= 16, 10'h0FF);
    end
  endtask
`endif

  initial begin
    bus.obst_req   = 1'b0;
    bus.err_req    = 1'b0;
    bus.arrive_req = 1'b0;
    bus.pwm_sig    = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    bus.pwm_sig = 1'b1; #1;
    expect_out("reset_hi", 1'b0, 2'b00, 1'b0, 10'h000);
    bus.pwm_sig = 1'b0; #1;
    expect_out("reset_lo", 1'b0, 2'b00, 1'b0, 10'h000);

    // Single error request: three 8-cycle bursts, idle 49 cycles after the pulse edge.
    pulse_err();
    expect_out("err_lat0", 1'b0, 2'b00, 1'b0, 10'h000);
    err_cycles("err", 1, 49);

    // Error and arrival in the same cycle.
    bus.err_req    = 1'b1;
    bus.arrive_req = 1'b1;
    tick();
    bus.err_req    = 1'b0;
    bus.arrive_req = 1'b0;
    err_cycles("both", 1, 49);
`ifdef PIEZO_CHIME_EN
    arr_cycles("both_arr");
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out($sformatf("both_noarr[%0d]", i), 1'b0, 2'b00, 1'b0, 10'h1FF);
    end
`endif

    // Obstacle during the second error beep, held 20 cycles.
    pulse_err();
    err_cycles("pre", 1, 19);
    bus.obst_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out($sformatf("obst[%0d]", i), 1'b1, 2'b01, 1'b1, 10'h1FF);
    end
    bus.obst_req = 1'b0;
    tick();
    expect_out("obst_rel", 1'b0, 2'b00, 1'b0, 10'h1FF);
    err_cycles("restart", 1, 49);

    // Obstacle from idle takes effect on the sampling edge.
    bus.obst_req = 1'b1;
    tick();
    expect_out("obst_idle", 1'b1, 2'b01, 1'b1, 10'h1FF);
    bus.obst_req = 1'b0;
    tick();
    expect_out("obst_idle_rel", 1'b0, 2'b00, 1'b0, 10'h1FF);

    // A second error pulse mid-pattern queues exactly one more pattern.
    pulse_err();
    err_cycles("dbl", 1, 9);
    bus.err_req = 1'b1;
    err_cycles("dbl", 10, 10);
    bus.err_req = 1'b0;
    err_cycles("dbl", 11, 49);
    err_cycles("dbl2", 1, 49);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("dbl_end[%0d]", i), 1'b0, 2'b00, 1'b0, 10'h1FF);
    end

    // Arrival request alone.
    bus.arrive_req = 1'b1;
    tick();
    bus.arrive_req = 1'b0;
`ifdef PIEZO_CHIME_EN
    arr_cycles("arr");
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      expect_out($sformatf("arr_off[%0d]", i), 1'b0, 2'b00, 1'b0, 10'h1FF);
    end
`endif

    // Reset in the middle of an error beep acts without a clock edge.
    pulse_err();
    err_cycles("mid", 1, 4);
    #3;
    bus.pwm_sig = 1'b1;
    rst_n       = 1'b0;
    #1;
    expect_out("rst_mid_hi", 1'b0, 2'b00, 1'b0, 10'h000);
    bus.pwm_sig = 1'b0; #1;
    expect_out("rst_mid_lo", 1'b0, 2'b00, 1'b0, 10'h000);

    // A pulse seen only during reset is lost.
    bus.err_req = 1'b1;
    @(posedge clk);
    #1;
    bus.err_req = 1'b0;
    rst_n       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("lost[%0d]", i), 1'b0, 2'b00, 1'b0, 10'h000);
    end

    // The first edge after release samples requests normally.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    pulse_err();
    err_cycles("post_rst", 1, 49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
